fib_inverse: RTL

Inverse Fibonacci unit: given a 16-bit value, it finds the smallest index `n` such that F(n) ≥ value, and flags whether the value is itself a Fibonacci number. It uses the same start/done request handshake and indexing as the `fibonacci` block: F(0)=0, F(1)=1, F(2)=1, F(5)=5, F(6)=8. It sits beside `fibonacci` as its decoder, mapping `fibonacci`'s `dout` values back to indices.

---
 rtl/fib_pkg.sv | 15 +
 rtl/fib_inverse.sv | 83 ++++++++
 2 files changed

// File: rtl/fib_pkg.sv
// Shared Fibonacci definitions: state encoding, width and seeds used by fibonacci and fib_inverse.
package fib_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } fib_state_t;

  localparam int unsigned FIB_WIDTH   = 16;
  localparam int unsigned FIB_MAX_IDX = 25;
  localparam int unsigned FIB_SEED0   = 0;
  localparam int unsigned FIB_SEED1   = 1;

endpackage

// File: rtl/fib_inverse.sv
// Inverse Fibonacci: finds the smallest n with F(n) >= din and flags exact Fibonacci hits.
module fib_inverse
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             exact,
  output logic             done
);

  localparam logic [WIDTH-1:0] NOne  = {{(WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   Seed0 = (WIDTH + 1)'(FIB_SEED0);
  localparam logic [WIDTH:0]   Seed1 = (WIDTH + 1)'(FIB_SEED1);

  fib_state_t       r_state;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH:0]   r_a;
  logic [WIDTH:0]   r_b;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_dout;
  logic             r_exact;
  logic             r_done;

  logic [WIDTH:0]   w_target_ext;
  logic             w_reached;

  // One extra bit on a/b keeps F(n) just past the largest target representable.
  assign w_target_ext = {1'b0, r_target};
  assign w_reached    = (r_a >= w_target_ext);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_target <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_n      <= '0;
      r_dout   <= '0;
      r_exact  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_target <= din;
            r_a      <= Seed0;
            r_b      <= Seed1;
            r_n      <= '0;
            r_done   <= 1'b0;
            r_state  <= StCalc;
          end
        end
        StCalc: begin
          // start is deliberately ignored here; the running search completes untouched.
          if (w_reached) begin
            r_dout  <= r_n;
            r_exact <= (r_a == w_target_ext);
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_a <= r_b;
            r_b <= r_a + r_b;
            r_n <= r_n + NOne;
          end
        end
        default: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign dout  = r_dout;
  assign exact = r_exact;
  assign done  = r_done;

endmodule
